// File: rtl/tx_frame_scheduler.sv
// Purpose: frames the continuous PRBS word stream into fixed-length frames separated by idle gaps, with SOF/TLAST and frame counting.
// Latency: 1 cycle from source handshake to output; start -> reload pulse next cycle -> SEND the cycle after.
// Backpressure: single output register; s_axis_tready = SEND && (!m_axis_tvalid || m_axis_tready); data/SOF/TLAST hold while stalled.
//
// Ports:
//   s_axi_aclk / s_axi_aresetn           clock, asynchronous active-low reset
//   i_start, i_stop                      run control (start pulse, sticky stop request)
//   i_frame_len, i_gap_len, i_num_frames run configuration, latched on an accepted start
//   o_src_enable, o_src_reload           PRBS source run enable and seed reload pulse
//   s_axis_*                             source word stream in
//   m_axis_*                             framed stream out (sof on first beat, tlast on last beat)
//   o_busy, o_frame_cnt                  activity flag and frames accepted downstream since start
// Build option: define TX_SCHED_RESEED_EN to reload the source seed at the start of every frame.
module tx_frame_scheduler #(
    parameter int C_DATA_WIDTH = 32,
    parameter int C_CNT_WIDTH  = 16
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_aresetn,
    input  logic                    i_start,
    input  logic                    i_stop,
    input  logic [C_CNT_WIDTH-1:0]  i_frame_len,
    input  logic [C_CNT_WIDTH-1:0]  i_gap_len,
    input  logic [C_CNT_WIDTH-1:0]  i_num_frames,
    output logic                    o_src_enable,
    output logic                    o_src_reload,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic [C_DATA_WIDTH-1:0] s_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_sof,
    output logic                    m_axis_tlast,
    output logic                    o_busy,
    output logic [C_CNT_WIDTH-1:0]  o_frame_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RELOAD = 2'd1,
        SEND   = 2'd2,
        GAP    = 2'd3
    } state_t;

    // State entered at the beginning of every frame after the first one.
`ifdef TX_SCHED_RESEED_EN
    localparam state_t FRAME_START = RELOAD;
`else
    localparam state_t FRAME_START = SEND;
`endif

    localparam logic [C_CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [C_CNT_WIDTH-1:0] CNT_ONE  = {{(C_CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                   state;
    logic [C_CNT_WIDTH-1:0]   frame_len_q;
    logic [C_CNT_WIDTH-1:0]   gap_len_q;
    logic [C_CNT_WIDTH-1:0]   num_frames_q;
    logic [C_CNT_WIDTH-1:0]   beat_cnt;
    logic [C_CNT_WIDTH-1:0]   gap_cnt;
    logic [C_CNT_WIDTH-1:0]   frames_sent;
    logic                     stop_flag;

    logic up_hs;
    logic dn_hs;
    logic last_beat;
    logic run_done;
    logic start_ok;

    assign s_axis_tready = (state == SEND) && (!m_axis_tvalid || m_axis_tready);
    assign up_hs         = s_axis_tvalid && s_axis_tready;
    assign dn_hs         = m_axis_tvalid && m_axis_tready;
    assign last_beat     = (beat_cnt == (frame_len_q - CNT_ONE));
    // frames_sent counts frames whose last beat was already taken from the
    // source, so the frame finishing now is number frames_sent+1.
    assign run_done      = ((num_frames_q != CNT_ZERO) && ((frames_sent + CNT_ONE) == num_frames_q))
                           || stop_flag;
    assign start_ok      = i_start && !o_busy && (i_frame_len != CNT_ZERO);
    assign o_busy        = (state != IDLE) || m_axis_tvalid;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state         <= IDLE;
            frame_len_q   <= '0;
            gap_len_q     <= '0;
            num_frames_q  <= '0;
            beat_cnt      <= '0;
            gap_cnt       <= '0;
            frames_sent   <= '0;
            stop_flag     <= 1'b0;
            o_src_enable  <= 1'b0;
            o_src_reload  <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_sof    <= 1'b0;
            m_axis_tlast  <= 1'b0;
            o_frame_cnt   <= '0;
        end else begin
            o_src_reload <= 1'b0;

            // Single-stage output register.
            if (up_hs) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= s_axis_tdata;
                m_axis_sof    <= (beat_cnt == CNT_ZERO);
                m_axis_tlast  <= last_beat;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            if (dn_hs && m_axis_tlast) begin
                o_frame_cnt <= o_frame_cnt + CNT_ONE;
            end

            if (i_stop && (state != IDLE)) begin
                stop_flag <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start_ok) begin
                        frame_len_q  <= i_frame_len;
                        gap_len_q    <= i_gap_len;
                        num_frames_q <= i_num_frames;
                        beat_cnt     <= '0;
                        frames_sent  <= '0;
                        o_frame_cnt  <= '0;
                        stop_flag    <= 1'b0;
                        o_src_reload <= 1'b1;
                        state        <= RELOAD;
                    end
                end
                RELOAD: begin
                    o_src_enable <= 1'b1;
                    state        <= SEND;
                end
                SEND: begin
                    if (up_hs) begin
                        if (last_beat) begin
                            beat_cnt    <= '0;
                            frames_sent <= frames_sent + CNT_ONE;
                            if (run_done) begin
                                o_src_enable <= 1'b0;
                                state        <= IDLE;
                            end else if (gap_len_q == CNT_ZERO) begin
                                o_src_enable <= (FRAME_START == SEND);
                                o_src_reload <= (FRAME_START == RELOAD);
                                state        <= FRAME_START;
                            end else begin
                                o_src_enable <= 1'b0;
                                gap_cnt      <= '0;
                                state        <= GAP;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + CNT_ONE;
                        end
                    end
                end
                GAP: begin
                    // Stays here exactly gap_len cycles.
                    if (gap_cnt == (gap_len_q - CNT_ONE)) begin
                        o_src_enable <= (FRAME_START == SEND);
                        o_src_reload <= (FRAME_START == RELOAD);
                        state        <= FRAME_START;
                    end else begin
                        gap_cnt <= gap_cnt + CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_frame_scheduler.sv
module tb_tx_frame_scheduler;
    localparam int DW = 32;
    localparam int CW = 16;
`ifdef TX_SCHED_RESEED_EN
    localparam bit RESEED = 1'b1;
`else
    localparam bit RESEED = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_start, i_stop;
    logic [CW-1:0] i_frame_len, i_gap_len, i_num_frames;
    logic          o_src_enable, o_src_reload;
    logic          s_axis_tvalid, s_axis_tready;
    logic [DW-1:0] s_axis_tdata;
    logic          m_axis_tvalid, m_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_sof, m_axis_tlast;
    logic          o_busy;
    logic [CW-1:0] o_frame_cnt;
    logic [DW-1:0] src_seq;

    tx_frame_scheduler #(.C_DATA_WIDTH(DW), .C_CNT_WIDTH(CW)) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .i_start       (i_start),
        .i_stop        (i_stop),
        .i_frame_len   (i_frame_len),
        .i_gap_len     (i_gap_len),
        .i_num_frames  (i_num_frames),
        .o_src_enable  (o_src_enable),
        .o_src_reload  (o_src_reload),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_sof    (m_axis_sof),
        .m_axis_tlast  (m_axis_tlast),
        .o_busy        (o_busy),
        .o_frame_cnt   (o_frame_cnt)
    );

    always #5 clk = ~clk;

    // Source stand-in: counting sequence 1,2,3... restarted by the seed reload,
    // always valid while enabled.
    assign s_axis_tvalid = o_src_enable;
    assign s_axis_tdata  = src_seq;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             src_seq <= 32'd1;
        else if (o_src_reload)                  src_seq <= 32'd1;
        else if (s_axis_tvalid && s_axis_tready) src_seq <= src_seq + 32'd1;
    end

    typedef struct packed {
        logic [31:0] dat;
        logic        sof;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    n_chk = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    exp_cnt = 0;
    int    dn_beats = 0;
    int    reload_cnt = 0;
    int    idle_run = 0;
    int    exp_gap = 0;
    int    last_tlast_cyc = 0;
    bit    seen_last = 1'b0;
    bit    stall_prev = 1'b0;
    beat_t prev_b;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected output of one run: nfr frames of len beats; the source restarts
    // at 1 on every reload, i.e. once per run or once per frame when reseeding.
    task automatic build(input int len, input int nfr, input bit rs);
        for (int f = 0; f < nfr; f++) begin
            for (int b = 0; b < len; b++) begin
                beat_t x;
                x.dat  = rs ? 32'(b + 1) : 32'(f * len + b + 1);
                x.sof  = (b == 0);
                x.last = (b == len - 1);
                exp_q.push_back(x);
            end
        end
    endtask

    // Compare process: every cycle, against the queue model.
    always @(negedge clk) begin
        beat_t cur;
        beat_t e;
        if (!rst_n) begin
            exp_q.delete();
            exp_cnt    = 0;
            stall_prev = 1'b0;
            seen_last  = 1'b0;
        end else begin
            cur.dat  = m_axis_tdata;
            cur.sof  = m_axis_sof;
            cur.last = m_axis_tlast;
            check("frame_cnt", 32'(o_frame_cnt), 32'(exp_cnt));
            if (stall_prev) begin
                check("stall_valid", 32'(m_axis_tvalid), 32'd1);
                check("stall_data", cur.dat, prev_b.dat);
                check("stall_flags", {30'd0, cur.sof, cur.last}, {30'd0, prev_b.sof, prev_b.last});
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", cur.dat, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", cur.dat, e.dat);
                    check("beat_sof", 32'(cur.sof), 32'(e.sof));
                    check("beat_last", 32'(cur.last), 32'(e.last));
                end
                if (cur.sof && seen_last)
                    check("gap_len", (idle_run >= exp_gap) ? 32'(exp_gap) : 32'(idle_run), 32'(exp_gap));
                dn_beats++;
                if (cur.last) begin
                    exp_cnt++;
                    seen_last      = 1'b1;
                    idle_run       = 0;
                    last_tlast_cyc = cyc;
                end
            end else if (!m_axis_tvalid) begin
                idle_run++;
            end
            if (o_src_reload) reload_cnt++;
            stall_prev = m_axis_tvalid && !m_axis_tready;
            prev_b     = cur;
            if (i_start && !o_busy && (i_frame_len != '0)) begin
                exp_cnt   = 0;
                seen_last = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int len, input int gap, input int nfr);
        tick();
        i_frame_len  = CW'(len);
        i_gap_len    = CW'(gap);
        i_num_frames = CW'(nfr);
        i_start      = 1'b1;
        tick();
        i_start      = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int i;
        i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (o_busy && i < maxc);
        check("idle_timeout", 32'(o_busy), 32'd0);
    endtask

    task automatic zero_checks();
        check("z_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("z_tdata", m_axis_tdata, 32'd0);
        check("z_sof", 32'(m_axis_sof), 32'd0);
        check("z_tlast", 32'(m_axis_tlast), 32'd0);
        check("z_src_en", 32'(o_src_enable), 32'd0);
        check("z_reload", 32'(o_src_reload), 32'd0);
        check("z_busy", 32'(o_busy), 32'd0);
        check("z_fcnt", 32'(o_frame_cnt), 32'd0);
        check("z_s_tready", 32'(s_axis_tready), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        i_start = 0; i_stop = 0; i_frame_len = 0; i_gap_len = 0; i_num_frames = 0;
        m_axis_tready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        zero_checks();
        tick();
        rst_n = 1'b1;

        // Start with frame_len=0 is ignored.
        reload_cnt = 0;
        run(0, 0, 1);
        repeat (3) tick();
        check("len0_busy", 32'(o_busy), 32'd0);
        check("len0_reload", 32'(reload_cnt), 32'd0);

        // 4 beats, no gap, one frame; start-to-output timing pinned.
        build(4, 1, RESEED);
        exp_gap = 0;
        tick();
        i_frame_len = 4; i_gap_len = 0; i_num_frames = 1; i_start = 1'b1;
        @(negedge clk);
        check("t1_reload_n", 32'(o_src_reload), 32'd0);
        tick();
        i_start = 1'b0;
        @(negedge clk);
        check("t1_reload_n1", 32'(o_src_reload), 32'd1);
        check("t1_en_n1", 32'(o_src_enable), 32'd0);
        @(negedge clk);
        check("t1_en_n2", 32'(o_src_enable), 32'd1);
        check("t1_reload_n2", 32'(o_src_reload), 32'd0);
        check("t1_s_tready_n2", 32'(s_axis_tready), 32'd1);
        @(negedge clk);
        check("t1_valid_n3", 32'(m_axis_tvalid), 32'd1);
        check("t1_sof_n3", 32'(m_axis_sof), 32'd1);
        check("t1_data_n3", m_axis_tdata, 32'd1);
        wait_idle(50);
        check("t1_busy_drop", 32'(cyc - last_tlast_cyc), 32'd1);
        check("t1_fcnt", 32'(o_frame_cnt), 32'd1);
        check("t1_drained", 32'(exp_q.size()), 32'd0);

        // 3 beats, gap 5, two frames.
        build(3, 2, RESEED);
        exp_gap = 5;
        run(3, 5, 2);
        wait_idle(200);
        check("t2_fcnt", 32'(o_frame_cnt), 32'd2);
        check("t2_drained", 32'(exp_q.size()), 32'd0);

        // Continuous 8-beat frames, stop requested during frame 2.
        build(8, 2, RESEED);
        exp_gap = 0;
        base = dn_beats;
        run(8, 0, 0);
        for (int i = 0; i < 200; i++) begin
            tick();
            if (dn_beats >= base + 11) break;
        end
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        wait_idle(200);
        repeat (10) tick();
        check("t3_fcnt", 32'(o_frame_cnt), 32'd2);
        check("t3_drained", 32'(exp_q.size()), 32'd0);
        check("t3_src_en", 32'(o_src_enable), 32'd0);
        check("t3_idle", 32'(o_busy), 32'd0);
        check("t3_beats", 32'(dn_beats - base), 32'd16);

        // Downstream ready toggling every cycle.
        build(4, 2, RESEED);
        run(4, 0, 2);
        for (int i = 0; i < 100; i++) begin
            tick();
            m_axis_tready = ~m_axis_tready;
            if (!o_busy) break;
        end
        m_axis_tready = 1'b1;
        wait_idle(50);
        check("t4_fcnt", 32'(o_frame_cnt), 32'd2);
        check("t4_drained", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a frame, then a fresh run.
        build(4, 1, RESEED);
        base = dn_beats;
        run(4, 0, 1);
        for (int i = 0; i < 50; i++) begin
            if (dn_beats >= base + 2) break;
            tick();
        end
        rst_n = 1'b0;
        @(negedge clk);
        zero_checks();
        tick();
        rst_n = 1'b1;
        build(4, 1, RESEED);
        run(4, 0, 1);
        wait_idle(50);
        check("t5_fcnt", 32'(o_frame_cnt), 32'd1);
        check("t5_drained", 32'(exp_q.size()), 32'd0);

        // Reload pulses per run: once per frame when reseeding, else once.
        reload_cnt = 0;
        build(2, 3, RESEED);
        exp_gap = 1;
        run(2, 1, 3);
        wait_idle(100);
        check("t6_reloads", 32'(reload_cnt), RESEED ? 32'd3 : 32'd1);
        check("t6_fcnt", 32'(o_frame_cnt), 32'd3);
        check("t6_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
